// File: rtl/intc_prio_pkg.sv
// Shared definitions for the intc_prio interrupt controller: FSM state
// encoding and the supported range of request channel counts.
package intc_prio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

endpackage : intc_prio_pkg

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder over N request bits. The highest index wins,
// with the scan start rotated so that index i_offset-1 has top priority.
module intc_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_offset,
    output logic [ID_W-1:0] o_idx,
    output logic            o_valid
);

    int w_pos;

    // Rank k maps to channel (k + offset) mod N; later (higher) ranks override.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (k + int'(i_offset)) % N;
            if (i_req[w_pos]) begin
                o_idx   = ID_W'(w_pos);
                o_valid = 1'b1;
            end
        end
    end

endmodule : intc_prio_enc

// File: rtl/intc_prio.sv
// Registered interrupt controller: rising-edge pending latch, masked selection
// and irq/ack handshake. Define INTC_ROUND_ROBIN_EN for rotating priority.
module intc_prio
    import intc_prio_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_mode,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    i_mask,
    input  logic            i_ack,
    output logic            o_irq,
    output logic [ID_W-1:0] o_irq_id,
    output logic [N-1:0]    o_pending
);

    logic [N-1:0]    r_req_q;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    w_set;
    logic [N-1:0]    w_clr;
    logic [N-1:0]    w_pending_next;
    logic [N-1:0]    w_elig;
    logic [ID_W-1:0] r_irq_id;
    logic [ID_W-1:0] w_irq_id_next;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_offset;
    logic            w_sel_valid;
    logic            w_ack_ok;
    state_e          r_state;
    state_e          w_state_next;

    assign w_ack_ok = (r_state == ST_ASSERT) && i_ack;
    assign w_set    = i_req & ~r_req_q;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clr
            assign w_clr[gi] = w_ack_ok && (r_irq_id == ID_W'(gi));
        end
    endgenerate

    // Set is OR-ed in last so a fresh edge beats a same-cycle acknowledge.
    assign w_pending_next = (r_pending & ~w_clr) | w_set;

    assign w_elig = i_mode ? (r_pending & i_mask)
                           : {{(N-1){1'b0}}, r_pending[0] & i_mask[0]};

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_last;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last <= '0;
        end else if (w_ack_ok) begin
            r_last <= r_irq_id;
        end
    end

    assign w_offset = r_last;
`else
    assign w_offset = '0;
`endif

    intc_prio_enc #(
        .N    (N),
        .ID_W (ID_W)
    ) u_enc (
        .i_req    (w_elig),
        .i_offset (w_offset),
        .o_idx    (w_sel),
        .o_valid  (w_sel_valid)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_irq_id  <= '0;
            r_state   <= ST_IDLE;
        end else begin
            r_req_q   <= i_req;
            r_pending <= w_pending_next;
            r_irq_id  <= w_irq_id_next;
            r_state   <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_irq_id_next = r_irq_id;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_next  = ST_ASSERT;
                    w_irq_id_next = w_sel;
                end
            end
            ST_ASSERT: begin
                if (i_ack) begin
                    w_state_next  = ST_GAP;
                    w_irq_id_next = '0;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_irq_id_next = '0;
            end
        endcase
    end

    assign o_irq     = (r_state == ST_ASSERT);
    assign o_irq_id  = r_irq_id;
    assign o_pending = r_pending;

endmodule : intc_prio

// File: tb/tb_intc_prio.sv
// Directed self-checking bench for intc_prio (N=4). Expected grant order
// follows INTC_ROUND_ROBIN_EN when it is defined.
module tb_intc_prio;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk;
    logic            reset_n;
    logic            mode;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            ack;
    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic [N-1:0]    pending;

    int n_tests;
    int n_fail;

    intc_prio #(
        .N    (N),
        .ID_W (ID_W)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (reset_n),
        .i_mode    (mode),
        .i_req     (req),
        .i_mask    (mask),
        .i_ack     (ack),
        .o_irq     (irq),
        .o_irq_id  (irq_id),
        .o_pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs driven afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        ack     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_irq(input string tag);
        for (int i = 0; i < 8 && !irq; i++) tick();
        chk(tag, 32'(irq), 32'd1);
    endtask

    logic [ID_W-1:0] exp_order [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        mode    = 1'b1;
        mask    = 4'b1111;
        req     = 4'b1111;
        ack     = 1'b0;

        // Reset with requests held high: all outputs cleared, edges latched after release.
        #3;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        tick();
        tick();
        chk("rst_pend_held", 32'(pending), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rel_pend", 32'(pending), 32'hF);

        // Fixed priority: channels 2 and 0.
        do_reset();
        mode = 1'b1;
        mask = 4'b1111;
        req  = 4'b0101;
        tick();
        req  = 4'b0000;
        chk("p2_pend", 32'(pending), 32'h5);
        chk("p2_irq_lat", 32'(irq), 32'd0);
        tick();
        chk("p2_irq", 32'(irq), 32'd1);
        chk("p2_id", 32'(irq_id), 32'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("p2_gap_irq", 32'(irq), 32'd0);
        chk("p2_gap_pend", 32'(pending), 32'h1);
        tick();
        chk("p2_idle_irq", 32'(irq), 32'd0);
        tick();
        chk("p0_irq", 32'(irq), 32'd1);
        chk("p0_id", 32'(irq_id), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("p0_pend", 32'(pending), 32'h0);
        tick();
        tick();
        chk("p0_quiet", 32'(irq), 32'd0);

        // Legacy mode: only channel 0 is serviced.
        do_reset();
        mode = 1'b0;
        req  = 4'b1110;
        tick();
        req  = 4'b0000;
        tick();
        tick();
        tick();
        chk("leg_noirq", 32'(irq), 32'd0);
        chk("leg_pend", 32'(pending), 32'hE);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("leg_pend0", 32'(pending), 32'hF);
        tick();
        chk("leg_irq", 32'(irq), 32'd1);
        chk("leg_id", 32'(irq_id), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("leg_clr", 32'(pending), 32'hE);

        // Masking and no preemption while asserted.
        do_reset();
        mode = 1'b1;
        mask = 4'b0111;
        req  = 4'b1000;
        tick();
        req  = 4'b0000;
        tick();
        tick();
        chk("msk_pend", 32'(pending), 32'h8);
        chk("msk_noirq", 32'(irq), 32'd0);
        mask = 4'b1111;
        tick();
        chk("msk_irq", 32'(irq), 32'd1);
        chk("msk_id", 32'(irq_id), 32'd3);
        mask = 4'b0000;
        tick();
        chk("msk_hold_irq", 32'(irq), 32'd1);
        chk("msk_hold_id", 32'(irq_id), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("msk_ack_pend", 32'(pending), 32'h0);

        // Ack outside ASSERT is ignored.
        mask = 4'b0000;
        req  = 4'b0100;
        tick();
        req  = 4'b0000;
        ack  = 1'b1;
        tick();
        tick();
        ack  = 1'b0;
        chk("idle_ack_pend", 32'(pending), 32'h4);
        chk("idle_ack_irq", 32'(irq), 32'd0);

        // Same-cycle set and clear on channel 1.
        do_reset();
        mask = 4'b1111;
        req  = 4'b0010;
        tick();
        req  = 4'b0000;
        tick();
        chk("col_id", 32'(irq_id), 32'd1);
        req = 4'b0010;
        ack = 1'b1;
        tick();
        req = 4'b0000;
        ack = 1'b0;
        chk("col_pend", 32'(pending), 32'h2);
        chk("col_gap", 32'(irq), 32'd0);
        tick();
        tick();
        chk("col_re_irq", 32'(irq), 32'd1);
        chk("col_re_id", 32'(irq_id), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Grant order with all channels continually re-triggered.
`ifdef INTC_ROUND_ROBIN_EN
        exp_order[0] = 2'd3;
        exp_order[1] = 2'd2;
        exp_order[2] = 2'd1;
        exp_order[3] = 2'd0;
        exp_order[4] = 2'd3;
`else
        for (int i = 0; i < 5; i++) exp_order[i] = 2'd3;
`endif
        do_reset();
        mode = 1'b1;
        mask = 4'b1111;
        req  = 4'b1111;
        tick();
        req  = 4'b0000;
        for (int g = 0; g < 5; g++) begin
            wait_irq($sformatf("ord_wait%0d", g));
            chk($sformatf("ord_id%0d", g), 32'(irq_id), 32'(exp_order[g]));
            req = 4'b1111;
            ack = 1'b1;
            tick();
            req = 4'b0000;
            ack = 1'b0;
        end

        // Asynchronous reset in the middle of an assertion.
        wait_irq("arst_wait");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_id", 32'(irq_id), 32'd0);
        chk("arst_pend", 32'(pending), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_intc_prio
